// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the program counter, fetches words over a req/ack port,
// hands them to decode over valid/ready, and applies branch redirects, halts and timeouts.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [31:0] br_base,
  input  logic [31:0] br_offset,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int unsigned CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_t          state_r, state_s;
  logic [31:0]     pc_r, pc_s;
  logic [CW-1:0]   wait_r, wait_s;
  logic            err_s;
  logic            capture_s;
  logic [31:0]     br_target_s;

  assign imem_addr = pc_r;

  // Next-state, next-pc and timeout logic; a redirect outranks every other event.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    wait_s      = wait_r;
    err_s       = fetch_err;
    capture_s   = 1'b0;
    br_target_s = br_base + br_offset;
    case (state_r)
      IDLE: begin
        if (br_taken) begin
          pc_s    = br_target_s;
          state_s = FETCH;
        end else if (halt) begin
          state_s = HALT;
        end else begin
          state_s = FETCH;
        end
      end
      FETCH: begin
        if (br_taken) begin
          pc_s    = br_target_s;
          wait_s  = {CW{1'b0}};
          state_s = FETCH;
        end else if (imem_ack) begin
          capture_s = 1'b1;
          wait_s    = {CW{1'b0}};
          state_s   = HOLD;
        end else if (wait_r == WAIT_LAST) begin
          err_s   = 1'b1;
          wait_s  = {CW{1'b0}};
          state_s = HALT;
        end else begin
          wait_s = wait_r + CW'(1);
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_s    = br_target_s;
          state_s = FETCH;
        end else if (instr_ready) begin
          pc_s    = pc_r + 32'd1;
          state_s = halt ? HALT : FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      HALT: begin
        // A timeout halt is sticky until reset.
        if (!halt && !fetch_err) begin
          state_s = FETCH;
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pc and registered output update; the processor's PC register runs on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      wait_r      <= {CW{1'b0}};
      fetch_err   <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      wait_r      <= wait_s;
      fetch_err   <= err_s;
      imem_req    <= (state_s == FETCH);
      instr_valid <= (state_s == HOLD);
      halted      <= (state_s == HALT);
      if (capture_s) begin
        instr    <= imem_rdata;
        instr_pc <= pc_r;
      end
    end
  end

endmodule
